// File: rtl/ilm_pkg.sv
// Shared types, widths and the accumulate helper for ilm_dot_acc.
// Define ILM_SAT_EN to make sat_add clamp on overflow instead of wrapping.
package ilm_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;

  localparam int unsigned PROD_W = 17;
  localparam int unsigned TERM_W = 18;
  localparam int unsigned SAT_W  = 64;

  // Adds acc+term and checks the result against a w-bit signed range; returns {ovf, sum}.
  function automatic logic [SAT_W:0] sat_add(
    input logic signed [SAT_W-1:0] acc,
    input logic signed [SAT_W-1:0] term,
    input int unsigned             w
  );
    logic signed [SAT_W:0] s;
    logic signed [SAT_W:0] vmax;
    logic signed [SAT_W:0] vmin;
    logic signed [SAT_W:0] r;
    logic                  ovf;
    s    = (SAT_W+1)'(acc) + (SAT_W+1)'(term);
    vmax = ((SAT_W+1)'(1) << (w - 1)) - (SAT_W+1)'(1);
    vmin = -((SAT_W+1)'(1) << (w - 1));
    ovf  = (s > vmax) || (s < vmin);
    r    = s;
`ifdef ILM_SAT_EN
    if (s > vmax) begin
      r = vmax;
    end else if (s < vmin) begin
      r = vmin;
    end
`endif
    return {ovf, SAT_W'(r)};
  endfunction

endpackage

// File: rtl/ilm_sign_apply.sv
// Converts a sign-magnitude product into a TERM_W-bit two's-complement term.
module ilm_sign_apply
  import ilm_pkg::*;
(
  input  logic [PROD_W-1:0]        i_product,
  input  logic                     i_sign,
  output logic signed [TERM_W-1:0] o_term
);

  logic signed [TERM_W-1:0] w_mag;

  // Negating a zero magnitude stays zero, so -0 needs no special case.
  assign w_mag  = {1'b0, i_product};
  assign o_term = i_sign ? -w_mag : w_mag;

endmodule

// File: rtl/ilm_dot_acc.sv
// Signed frame accumulator for the log-multiplier products, with a registered valid/ready result.
// Define ILM_SAT_EN for saturating accumulation; otherwise the sum wraps and flags overflow.
module ilm_dot_acc
  import ilm_pkg::*;
#(
  parameter int unsigned ACC_W   = 24,
  parameter int unsigned MAX_LEN = 256,
  parameter int unsigned CNT_W   = $clog2(MAX_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [16:0]       in_product,
  input  logic              in_sign,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf,
  output logic              out_len_err
);

  state_e                  r_state, w_state_n;
  logic signed [ACC_W-1:0] r_acc, w_acc_n;
  logic [CNT_W-1:0]        r_count, w_count_n;
  logic                    r_ovf, w_ovf_n;
  logic                    r_out_valid, w_out_valid_n;
  logic [ACC_W-1:0]        r_out_acc, w_out_acc_n;
  logic [CNT_W-1:0]        r_out_count, w_out_count_n;
  logic                    r_out_ovf, w_out_ovf_n;
  logic                    r_out_len_err, w_out_len_err_n;

  logic signed [TERM_W-1:0] w_term;
  logic                     w_add_ovf;
  logic signed [SAT_W-1:0]  w_add_sum;
  logic signed [ACC_W-1:0]  w_nxt;
  logic [CNT_W-1:0]         w_cnt_inc;
  logic                     w_accept;
  logic                     w_at_max;
  logic                     w_close;

  ilm_sign_apply u_sign_apply (
    .i_product (in_product),
    .i_sign    (in_sign),
    .o_term    (w_term)
  );

  // acc is zero outside ACCUM, so the same adder also forms the first term of a frame.
  assign in_ready  = (r_state != DONE) || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign {w_add_ovf, w_add_sum} = sat_add(SAT_W'(r_acc), SAT_W'(w_term), ACC_W);
  assign w_nxt     = ACC_W'(w_add_sum);
  assign w_cnt_inc = r_count + CNT_W'(1);
  assign w_at_max  = (w_cnt_inc == CNT_W'(MAX_LEN));
  assign w_close   = in_last || w_at_max;

  // Next-state and next-output logic.
  always_comb begin
    w_state_n       = r_state;
    w_acc_n         = r_acc;
    w_count_n       = r_count;
    w_ovf_n         = r_ovf;
    w_out_valid_n   = r_out_valid;
    w_out_acc_n     = r_out_acc;
    w_out_count_n   = r_out_count;
    w_out_ovf_n     = r_out_ovf;
    w_out_len_err_n = r_out_len_err;

    if ((r_state == DONE) && out_ready) begin
      w_out_valid_n = 1'b0;
      w_state_n     = IDLE;
    end

    if (w_accept) begin
      if (w_close) begin
        w_out_valid_n   = 1'b1;
        w_out_acc_n     = w_nxt;
        w_out_count_n   = w_cnt_inc;
        w_out_ovf_n     = r_ovf | w_add_ovf;
        w_out_len_err_n = !in_last && w_at_max;
        w_acc_n         = '0;
        w_count_n       = '0;
        w_ovf_n         = 1'b0;
        w_state_n       = DONE;
      end else begin
        w_acc_n   = w_nxt;
        w_count_n = w_cnt_inc;
        w_ovf_n   = r_ovf | w_add_ovf;
        w_state_n = ACCUM;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_acc         <= '0;
      r_count       <= '0;
      r_ovf         <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_acc     <= '0;
      r_out_count   <= '0;
      r_out_ovf     <= 1'b0;
      r_out_len_err <= 1'b0;
    end else begin
      r_state       <= w_state_n;
      r_acc         <= w_acc_n;
      r_count       <= w_count_n;
      r_ovf         <= w_ovf_n;
      r_out_valid   <= w_out_valid_n;
      r_out_acc     <= w_out_acc_n;
      r_out_count   <= w_out_count_n;
      r_out_ovf     <= w_out_ovf_n;
      r_out_len_err <= w_out_len_err_n;
    end
  end

  assign out_valid   = r_out_valid;
  assign out_acc     = r_out_acc;
  assign out_count   = r_out_count;
  assign out_ovf     = r_out_ovf;
  assign out_len_err = r_out_len_err;

endmodule
